control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Mini SRC control unit. It drives every CPU_datapath control input (PCout, MARin, GRA, Rout_in, ...)
//  and reads back the datapath's opcode output.
//  Each instruction runs as fetch T0-T2, then an opcode-specific execute sequence T3-T7, one state per clk.
//  Sits beside CPU_datapath at the top level; together they form the CPU.
// PARAMETERS
//  OP_W             5  opcode width, matches IR[31:27]
//  HALT_ON_ILLEGAL  0  1: undefined opcode enters HALT; 0: undefined opcode executes as nop
// PORTS
//  clk            in   1     system clock, all state updates on posedge
//  rst            in   1     synchronous, active-low reset
//  opcode         in   OP_W  IR[31:27] from datapath, valid from T3 onward
//  run            out  1     1 while sequencing; 0 in RESET and HALT
//  PCout,Zhighout,Zlowout,MDRout,HIout,LOout,InPortout,Yout,Baout,Cout,Rout_in  out 1 each  bus drivers
//  MARin,MDRin,PCin,IRin,Yin,HIin,LOin,ZIn,R_enableIn,enableOutPort  out 1 each  register loads
//  IncPC,Read,RAMin,RAMrd,GRA,GRB,GRC  out 1 each  PC increment, MDR mux select, RAM write/read, reg-field select
// BEHAVIOUR
//  - Reset: sampled on posedge clk when rst==0. Enters RESET. run=0 and all control outputs 0.
//    Takes priority over any state, including mid-instruction; no partial writes complete.
//  - RESET -> T0 on the first posedge with rst==1.
//  - Moore outputs: decoded only from registered state, so every output is stable for the whole cycle.
//  - At most one bus driver is active per state.
//  - Fetch (all opcodes):
//    T0: PCout MARin IncPC RAMrd
//    T1: RAMrd Read MDRin
//    T2: MDRout IRin
//  - opcode is sampled in T3 only; the execute path is chosen from it there.
//  - Opcode table and execute steps. After the last listed step the next state is T0.
//    ld 00000:   T3 GRB Baout Yin | T4 Cout ZIn | T5 Zlowout MARin RAMrd | T6 RAMrd Read MDRin | T7 MDRout GRA R_enableIn
//    ldi 00001:  T3 GRB Baout Yin | T4 Cout ZIn | T5 Zlowout GRA R_enableIn
//    st 00010:   T3 GRB Baout Yin | T4 Cout ZIn | T5 Zlowout MARin | T6 GRA Rout_in MDRin (Read=0) | T7 RAMin
//    add 00011, sub 00100, and 00101, or 00110:
//                T3 GRB Rout_in Yin | T4 GRC Rout_in ZIn | T5 Zlowout GRA R_enableIn
//    addi 01100, andi 01101, ori 01110:
//                T3 GRB Rout_in Yin | T4 Cout ZIn | T5 Zlowout GRA R_enableIn
//    div 01111, mul 10000:
//                T3 GRA Rout_in Yin | T4 GRB Rout_in ZIn | T5 Zlowout LOin | T6 Zhighout HIin
//    out 10110:  T3 GRA Rout_in enableOutPort
//    mfhi 10111: T3 GRA R_enableIn HIout
//    mflo 11000: T3 GRA R_enableIn LOout
//    nop 11001:  T3 all outputs 0
//    halt 11010: T3 -> HALT
//    in 10101:   T3 GRA R_enableIn InPortout
//  - Instruction lengths in cycles: ld/st 8, mul/div 7, ALU/imm/ldi 6, move/in/out/nop 4.
//  - HALT: all outputs 0, run=0. Absorbing; exits only via rst==0.
//  - Undefined opcode: nop path (4 cycles) if HALT_ON_ILLEGAL=0, else HALT at T3.
//  - PCin is never asserted: there are no branch/jump opcodes in this revision.
//  - The opcode input is ignored outside T3, so glitches during fetch have no effect.
// TESTING
//  1. rst=0 for 2 clks -> all outputs 0, run=0. Release -> T0 on next edge: PCout=MARin=IncPC=RAMrd=1 for exactly 1 cycle.
//  2. opcode=11000 (mflo), LO=15 -> T3 asserts GRA R_enableIn LOout only. Ra reads 15. Next state T0 (4-cycle period).
//  3. opcode=00011 (add), R2=8, R3=2 -> T3..T5 sequence as tabled. Ra=10 after T5. Never 2 bus drivers high in any cycle.
//  4. opcode=00000 (ld), Rb=0, C=0x5, mem[5]=0xDEAD -> Ra=0xDEAD after T7. Total 8 cycles.
//  5. opcode=00010 (st), then opcode=11010 (halt) -> RAMin exactly 1 cycle in T7. HALT reached with run=0.
//     Outputs stay 0 for 10 clks; rst pulse -> RESET then T0.
//  6. rst=0 asserted during T5 of mul -> no LOin/HIin pulse after the reset edge. Restarts at T0.
//     Opcode 11111 with HALT_ON_ILLEGAL=0 -> nop timing; with HALT_ON_ILLEGAL=1 -> HALT.

Source files
------------

// File: rtl/control_sequencer.sv
// Mini SRC control unit: fetch T0-T2, then an opcode-specific execute
// sequence T3-T7. All control outputs are decoded from registered state.
module control_sequencer #(
    parameter int OP_W            = 5,
    parameter int HALT_ON_ILLEGAL = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] opcode,
    output logic            run,
    output logic            PCout,
    output logic            Zhighout,
    output logic            Zlowout,
    output logic            MDRout,
    output logic            HIout,
    output logic            LOout,
    output logic            InPortout,
    output logic            Yout,
    output logic            Baout,
    output logic            Cout,
    output logic            Rout_in,
    output logic            MARin,
    output logic            MDRin,
    output logic            PCin,
    output logic            IRin,
    output logic            Yin,
    output logic            HIin,
    output logic            LOin,
    output logic            ZIn,
    output logic            R_enableIn,
    output logic            enableOutPort,
    output logic            IncPC,
    output logic            Read,
    output logic            RAMin,
    output logic            RAMrd,
    output logic            GRA,
    output logic            GRB,
    output logic            GRC
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MD,
        C_OUT, C_MFHI, C_MFLO, C_IN, C_NOP, C_HALT
    } cls_t;

    state_t state, next_state;
    cls_t   op_cls, cls_q, exec_cls;

    // Group opcodes into classes that share an execute sequence.
    function automatic cls_t decode(input logic [OP_W-1:0] op);
        case (op)
            OP_W'(5'b00000): return C_LD;
            OP_W'(5'b00001): return C_LDI;
            OP_W'(5'b00010): return C_ST;
            OP_W'(5'b00011), OP_W'(5'b00100),
            OP_W'(5'b00101), OP_W'(5'b00110): return C_ALU;
            OP_W'(5'b01100), OP_W'(5'b01101),
            OP_W'(5'b01110): return C_IMM;
            OP_W'(5'b01111), OP_W'(5'b10000): return C_MD;
            OP_W'(5'b10101): return C_IN;
            OP_W'(5'b10110): return C_OUT;
            OP_W'(5'b10111): return C_MFHI;
            OP_W'(5'b11000): return C_MFLO;
            OP_W'(5'b11001): return C_NOP;
            OP_W'(5'b11010): return C_HALT;
            default: return (HALT_ON_ILLEGAL != 0) ? C_HALT : C_NOP;
        endcase
    endfunction

    assign op_cls = decode(opcode);
    // The opcode is only looked at in T3; later steps use the latched class.
    assign exec_cls = (state == S_T3) ? op_cls : cls_q;

    // State register; reset wins over every state, including mid-instruction.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_RESET;
        else      state <= next_state;
    end

    // Latch the instruction class at the end of T3 for the remaining steps.
    always_ff @(posedge clk) begin
        if (state == S_T3) cls_q <= op_cls;
    end

    // Next-state: fetch is common, execute length depends on the class.
    always_comb begin
        next_state = state;
        case (state)
            S_RESET: next_state = S_T0;
            S_T0:    next_state = S_T1;
            S_T1:    next_state = S_T2;
            S_T2:    next_state = S_T3;
            S_T3: begin
                case (exec_cls)
                    C_HALT: next_state = S_HALT;
                    C_OUT, C_MFHI, C_MFLO, C_IN, C_NOP: next_state = S_T0;
                    default: next_state = S_T4;
                endcase
            end
            S_T4:    next_state = S_T5;
            S_T5:    next_state = (exec_cls == C_LD || exec_cls == C_ST || exec_cls == C_MD)
                                  ? S_T6 : S_T0;
            S_T6:    next_state = (exec_cls == C_MD) ? S_T0 : S_T7;
            S_T7:    next_state = S_T0;
            S_HALT:  next_state = S_HALT;
            default: next_state = S_RESET;
        endcase
    end

    // Moore output decode; everything defaults low, one bus driver at most.
    always_comb begin
        run = 1'b0;
        PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
        HIout = 1'b0; LOout = 1'b0; InPortout = 1'b0; Yout = 1'b0;
        Baout = 1'b0; Cout = 1'b0; Rout_in = 1'b0;
        MARin = 1'b0; MDRin = 1'b0; PCin = 1'b0; IRin = 1'b0; Yin = 1'b0;
        HIin = 1'b0; LOin = 1'b0; ZIn = 1'b0; R_enableIn = 1'b0; enableOutPort = 1'b0;
        IncPC = 1'b0; Read = 1'b0; RAMin = 1'b0; RAMrd = 1'b0;
        GRA = 1'b0; GRB = 1'b0; GRC = 1'b0;
        run = (state != S_RESET) && (state != S_HALT);
        case (state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RAMrd = 1'b1; end
            S_T1: begin RAMrd = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                case (exec_cls)
                    C_LD, C_LDI, C_ST: begin GRB = 1'b1; Baout = 1'b1; Yin = 1'b1; end
                    C_ALU, C_IMM:      begin GRB = 1'b1; Rout_in = 1'b1; Yin = 1'b1; end
                    C_MD:              begin GRA = 1'b1; Rout_in = 1'b1; Yin = 1'b1; end
                    C_OUT:  begin GRA = 1'b1; Rout_in = 1'b1; enableOutPort = 1'b1; end
                    C_MFHI: begin GRA = 1'b1; R_enableIn = 1'b1; HIout = 1'b1; end
                    C_MFLO: begin GRA = 1'b1; R_enableIn = 1'b1; LOout = 1'b1; end
                    C_IN:   begin GRA = 1'b1; R_enableIn = 1'b1; InPortout = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (exec_cls)
                    C_ALU: begin GRC = 1'b1; Rout_in = 1'b1; ZIn = 1'b1; end
                    C_MD:  begin GRB = 1'b1; Rout_in = 1'b1; ZIn = 1'b1; end
                    default: begin Cout = 1'b1; ZIn = 1'b1; end
                endcase
            end
            S_T5: begin
                Zlowout = 1'b1;
                case (exec_cls)
                    C_LD:    begin MARin = 1'b1; RAMrd = 1'b1; end
                    C_ST:    MARin = 1'b1;
                    C_MD:    LOin = 1'b1;
                    default: begin GRA = 1'b1; R_enableIn = 1'b1; end
                endcase
            end
            S_T6: begin
                case (exec_cls)
                    C_LD:    begin RAMrd = 1'b1; Read = 1'b1; MDRin = 1'b1; end
                    C_ST:    begin GRA = 1'b1; Rout_in = 1'b1; MDRin = 1'b1; end
                    default: begin Zhighout = 1'b1; HIin = 1'b1; end
                endcase
            end
            S_T7: begin
                if (exec_cls == C_ST) RAMin = 1'b1;
                else begin MDRout = 1'b1; GRA = 1'b1; R_enableIn = 1'b1; end
            end
            default: ;
        endcase
    end

endmodule
